// File: rtl/knn_sort_controller.sv
// knn_sort_controller
// Sequences one KNN classification: waits for the distance unit, kicks the
// sorter, captures its sorted label array, takes a K-nearest majority vote
// and returns the winning class on a valid/ready handshake.
module knn_sort_controller #(
    parameter int N       = 8,
    parameter int W       = 16,
    parameter int TYPE_W  = 2,
    parameter int K       = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    input  logic                  i_dist_done,
    output logic                  o_sort_start,
    input  logic                  i_sort_valid,
    input  logic [N*TYPE_W-1:0]   i_sorted_types,
    output logic [TYPE_W-1:0]     o_class_out,
    output logic                  o_class_valid,
    input  logic                  i_class_ready,
    output logic                  o_timeout_err
);

    localparam int C     = 1 << TYPE_W;
    localparam int CNT_W = $clog2(K + 1);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int TO_W  = 8;

    // Parameter sanity: W only has to agree with distance_sort, but must be legal.
    if (W < 1)                       $error("W must be at least 1");
    if (K < 1 || K > N)              $error("K must be in 1..N");
    if (TIMEOUT < 1 || TIMEOUT > 255) $error("TIMEOUT must be in 1..255");

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DIST,
        S_SORT,
        S_WAIT_SORT,
        S_VOTE,
        S_ARGMAX,
        S_OUTPUT
    } state_t;

    state_t                           r_state;
    logic                             r_busy;
    logic                             r_sort_start;
    logic [TYPE_W-1:0]                r_class_out;
    logic                             r_class_valid;
    logic                             r_timeout_err;
    logic [TO_W-1:0]                  r_tcnt;
    logic [IDX_W-1:0]                 r_idx;
    logic [TYPE_W-1:0]                r_cls;
    logic [CNT_W-1:0]                 r_best_cnt;
    logic [TYPE_W-1:0]                r_best_cls;
    logic [N-1:0][TYPE_W-1:0]         r_captured;
    logic [CNT_W-1:0]                 r_count [C];

    logic [TYPE_W-1:0]                w_vote_cls;
    logic [CNT_W-1:0]                 w_cur_cnt;
    logic                             w_cur_wins;
    logic [TO_W-1:0]                  w_tcnt_next;

    // Current voter label, current candidate count and the strict-greater test
    // that makes ties fall to the lowest class index.
    always_comb begin
        w_vote_cls  = r_captured[r_idx];
        w_cur_cnt   = r_count[r_cls];
        w_cur_wins  = (w_cur_cnt > r_best_cnt);
        w_tcnt_next = r_tcnt + TO_W'(1);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_sort_start  <= 1'b0;
            r_class_out   <= '0;
            r_class_valid <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tcnt        <= '0;
            r_idx         <= '0;
            r_cls         <= '0;
            r_best_cnt    <= '0;
            r_best_cls    <= '0;
            r_captured    <= '0;
            for (int c = 0; c < C; c++) r_count[c] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state       <= S_WAIT_DIST;
                        r_busy        <= 1'b1;
                        r_timeout_err <= 1'b0;
                        r_best_cnt    <= '0;
                        r_best_cls    <= '0;
                        for (int c = 0; c < C; c++) r_count[c] <= '0;
                    end
                end
                S_WAIT_DIST: begin
                    if (i_dist_done) begin
                        r_state      <= S_SORT;
                        r_sort_start <= 1'b1;
                    end
                end
                S_SORT: begin
                    r_sort_start <= 1'b0;
                    r_tcnt       <= '0;
                    r_state      <= S_WAIT_SORT;
                end
                S_WAIT_SORT: begin
                    // A sorter result arriving on the final cycle still counts.
                    if (i_sort_valid) begin
                        r_captured <= i_sorted_types;
                        r_idx      <= '0;
                        r_state    <= S_VOTE;
                    end else begin
                        r_tcnt <= w_tcnt_next;
                        if (w_tcnt_next == TO_W'(TIMEOUT)) begin
                            r_timeout_err <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= S_IDLE;
                        end
                    end
                end
                S_VOTE: begin
                    r_count[w_vote_cls] <= r_count[w_vote_cls] + CNT_W'(1);
                    r_idx               <= r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(K - 1)) begin
                        r_cls      <= '0;
                        r_best_cnt <= '0;
                        r_best_cls <= '0;
                        r_state    <= S_ARGMAX;
                    end
                end
                S_ARGMAX: begin
                    if (w_cur_wins) begin
                        r_best_cnt <= w_cur_cnt;
                        r_best_cls <= r_cls;
                    end
                    if (r_cls == TYPE_W'(C - 1)) begin
                        r_class_out   <= w_cur_wins ? r_cls : r_best_cls;
                        r_class_valid <= 1'b1;
                        r_state       <= S_OUTPUT;
                    end else begin
                        r_cls <= r_cls + TYPE_W'(1);
                    end
                end
                S_OUTPUT: begin
                    if (i_class_ready) begin
                        r_class_valid <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_sort_start  = r_sort_start;
    assign o_class_out   = r_class_out;
    assign o_class_valid = r_class_valid;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: doc/knn_sort_controller.md
# knn_sort_controller

Sequencer for the KNN classification datapath. It accepts a classification request, waits for the distance unit to finish, and pulses the sorter's `done` input. It then waits for `valid_sort` and captures the sorted type array. It runs a K-nearest majority vote over the first K entries and returns the winning class on a valid/ready handshake. It sits between the top-level request interface, the distance unit and `distance_sort`.

## Interface
- `N`, 8: number of training samples; must match the sorter's N.
- `W`, 16: distance width; not used internally, carried for consistency with `distance_sort`.
- `TYPE_W`, 2: class label width; number of classes is C = 2^TYPE_W.
- `K`, 3: neighbours that vote; legal range 1 <= K <= N.
- `TIMEOUT`, 15: maximum cycles spent in WAIT_SORT before aborting; legal range 1..255.

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request a classification; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `dist_done` in 1: distance unit finished; sampled only in WAIT_DIST.
- `sort_start` out 1: one-cycle pulse driven to the sorter's `done` input.
- `sort_valid` in 1: sorter's `valid_sort`; sampled only in WAIT_SORT.
- `sorted_types` in N*TYPE_W: sorted type array; element i occupies bits [i*TYPE_W +: TYPE_W], and element 0 is the nearest neighbour.
- `class_out` out TYPE_W: winning class; stable while `class_valid` is high.
- `class_valid` out 1: result available.
- `class_ready` in 1: consumer accepts the result.
- `timeout_err` out 1: sticky abort flag; set on sort timeout, cleared when the next accepted `start` is sampled.

## Operation
- States: IDLE, WAIT_DIST, SORT, WAIT_SORT, VOTE, ARGMAX, OUTPUT.
- IDLE -> WAIT_DIST on `start`. This also clears `timeout_err`, all vote counters and the max registers.
- WAIT_DIST -> SORT on `dist_done`. There is no timeout in WAIT_DIST.
- SORT:
  - Registered `sort_start` = 1 for exactly this one cycle.
  - Unconditional -> WAIT_SORT, with the timeout counter cleared.
- WAIT_SORT:
  - On `sort_valid`: capture `sorted_types` into an internal register, set index = 0, -> VOTE.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT with no `sort_valid`: set `timeout_err`, -> IDLE.
  - `sort_valid` wins over timeout in the same cycle.
- VOTE:
  - Each cycle, increment count[captured[index]], where the counter width is clog2(K+1).
  - Increment index.
  - After K cycles -> ARGMAX with class index = 0, best count = 0, best class = 0.
- ARGMAX:
  - Each cycle, compare count[c] against the best count using strict greater-than, so ties resolve to the lowest class index.
  - After C cycles, register the winner into `class_out` -> OUTPUT.
- OUTPUT:
  - `class_valid` = 1, holding `class_out` until `class_ready`.
  - `class_valid` && `class_ready` -> IDLE, with `class_valid` low the next cycle.
- Ignored inputs:
  - `start` outside IDLE, including the cycle a handshake completes.
  - `dist_done` outside WAIT_DIST.
  - `sort_valid` outside WAIT_SORT.
- `rst` asserted in any state forces IDLE on the next edge and abandons any in-flight request.
- Reset values: `busy` = 0, `sort_start` = 0, `class_out` = 0, `class_valid` = 0, `timeout_err` = 0; counters, index and captured register = 0.

## Timing
- `busy` rises the cycle after `start` is sampled.
- `sort_start` is high in the single cycle after `dist_done` is sampled.
- Latency from the edge sampling `sort_valid` to `class_valid` high is K + C cycles; with the defaults this is 7.
- `class_out` changes only on the ARGMAX -> OUTPUT edge and after reset.
- Minimum back-to-back period is `start` -> result -> IDLE; a new `start` is sampled no earlier than one cycle after the handshake.
- `timeout_err` is set on the edge where the counter reaches TIMEOUT, exactly TIMEOUT cycles after entering WAIT_SORT.

## Test plan
- **Majority:**
  - Stimulus: `start`, `dist_done` 3 cycles later, `sort_valid` 3 cycles after `sort_start`; `sorted_types` elements 0..2 = 2,1,2 and the rest 3.
  - Response: `sort_start` is a single-cycle pulse; `class_out` = 2; `class_valid` high exactly 7 cycles after `sort_valid`.
- **Tie:**
  - Stimulus: elements 0..2 = 3,1,0.
  - Response: `class_out` = 0, the lowest index.
- **Backpressure:**
  - Stimulus: hold `class_ready` = 0 for 10 cycles while pulsing `start` in that window.
  - Response: `class_valid` and `class_out` stay stable; the extra `start` is ignored; `busy` drops the cycle after `class_ready` = 1.
- **Timeout:**
  - Stimulus: never assert `sort_valid`.
  - Response: `timeout_err` = 1 after 15 cycles in WAIT_SORT, return to IDLE; the next `start` clears it, and a normal run then completes.
- **Reset mid-operation:**
  - Stimulus: assert `rst` during VOTE, then issue a full request with elements 0..2 = 1,1,0.
  - Response: all outputs reach their reset values on the next edge; no stale counts carry over; `class_out` = 1.
- **Spurious inputs:**
  - Stimulus: `dist_done` and `sort_valid` pulses while in IDLE.
  - Response: no state change; `busy` stays 0.
